// File: rtl/axi_arbiter_pkg.sv
// Shared constants for the two-master AXI arbiter: bus widths, FSM encodings,
// master indices and the payload bundles muxed through the arbiter.
package axi_arbiter_pkg;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned STRB_W  = DATA_W / 8;
    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_ADDR = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_ADDR = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_RESP = 2'd3;

    // m0 = I-cache, m1 = D-cache
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef struct packed {
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ax_ctl_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_beat_t;

endpackage

// File: rtl/axi_arbiter_if.sv
// AXI read/write channel bundle used for both the cache-side ports and the
// downstream port; "master" is the side that issues addresses.
interface axi_arbiter_if #(
    parameter int unsigned ADDR_W = 64
);
    import axi_arbiter_pkg::*;

    logic                ar_valid;
    logic [ADDR_W-1:0]   ar_addr;
    logic [LEN_W-1:0]    ar_len;
    logic [SIZE_W-1:0]   ar_size;
    logic [BURST_W-1:0]  ar_burst;
    logic                ar_ready;
    logic                r_valid;
    logic                r_last;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;

    logic                aw_valid;
    logic [ADDR_W-1:0]   aw_addr;
    logic [LEN_W-1:0]    aw_len;
    logic [SIZE_W-1:0]   aw_size;
    logic [BURST_W-1:0]  aw_burst;
    logic                aw_ready;
    logic                w_valid;
    logic [DATA_W-1:0]   w_data;
    logic [STRB_W-1:0]   w_strb;
    logic                w_last;
    logic                w_ready;
    logic                b_valid;
    logic                b_ready;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst,
        output w_valid, w_data, w_strb, w_last, b_ready,
        input  ar_ready, r_valid, r_last, r_rdata,
        input  aw_ready, w_ready, b_valid
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_size, ar_burst, r_ready,
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst,
        input  w_valid, w_data, w_strb, w_last, b_ready,
        output ar_ready, r_valid, r_last, r_rdata,
        output aw_ready, w_ready, b_valid
    );

endinterface

// File: rtl/axi_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker; the registered last-grant pointer doubles
// as the held grant, updated only when the owning FSM leaves IDLE.
module rr_arbiter2
    import axi_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant
);

    logic pick_c;

    // On a tie, favour the master that did not win last time.
    always_comb begin
        pick_c = M0;
        if (req == 2'b11) begin
            pick_c = ~grant;
        end else if (req[1]) begin
            pick_c = M1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant <= M0;
        end else if (update) begin
            grant <= pick_c;
        end
    end

endmodule

// File: rtl/axi_arbiter.sv
// Arbitrates I-cache (m0) and D-cache (m1) AXI traffic onto one downstream port,
// with independent read/write FSMs that never overlap a read with a write.
module axi_arbiter
    import axi_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
) (
    input  logic          clock,
    input  logic          reset,
    axi_arbiter_if.slave  m0,
    axi_arbiter_if.slave  m1,
    axi_arbiter_if.master s
);

    logic [1:0]        r_state;
    logic [1:0]        r_next;
    logic [1:0]        w_state;
    logic [1:0]        w_next;
    logic              r_grant;
    logic              w_grant;
    logic              r_start_c;
    logic              w_start_c;
    logic              rd_req;
    logic              wr_req;

    logic              ar_sel_valid;
    logic [ADDR_W-1:0] ar_sel_addr;
    ax_ctl_t           ar_sel_ctl;
    logic              r_sel_ready;
    logic              aw_sel_valid;
    logic [ADDR_W-1:0] aw_sel_addr;
    ax_ctl_t           aw_sel_ctl;
    logic              w_sel_valid;
    w_beat_t           w_sel;
    logic              b_sel_ready;

    assign rd_req = m0.ar_valid | m1.ar_valid;
    assign wr_req = m0.aw_valid | m1.aw_valid;

    rr_arbiter2 u_rd_rr (
        .clock  (clock),
        .reset  (reset),
        .req    ({m1.ar_valid, m0.ar_valid}),
        .update (r_start_c),
        .grant  (r_grant)
    );

    rr_arbiter2 u_wr_rr (
        .clock  (clock),
        .reset  (reset),
        .req    ({m1.aw_valid, m0.aw_valid}),
        .update (w_start_c),
        .grant  (w_grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
        end
    end

    // Granted master's read-side signals.
    always_comb begin
        ar_sel_valid = m0.ar_valid;
        ar_sel_addr  = m0.ar_addr;
        ar_sel_ctl   = {m0.ar_len, m0.ar_size, m0.ar_burst};
        r_sel_ready  = m0.r_ready;
        if (r_grant == M1) begin
            ar_sel_valid = m1.ar_valid;
            ar_sel_addr  = m1.ar_addr;
            ar_sel_ctl   = {m1.ar_len, m1.ar_size, m1.ar_burst};
            r_sel_ready  = m1.r_ready;
        end
    end

    // Granted master's write-side signals.
    always_comb begin
        aw_sel_valid = m0.aw_valid;
        aw_sel_addr  = m0.aw_addr;
        aw_sel_ctl   = {m0.aw_len, m0.aw_size, m0.aw_burst};
        w_sel_valid  = m0.w_valid;
        w_sel        = {m0.w_data, m0.w_strb, m0.w_last};
        b_sel_ready  = m0.b_ready;
        if (w_grant == M1) begin
            aw_sel_valid = m1.aw_valid;
            aw_sel_addr  = m1.aw_addr;
            aw_sel_ctl   = {m1.aw_len, m1.aw_size, m1.aw_burst};
            w_sel_valid  = m1.w_valid;
            w_sel        = {m1.w_data, m1.w_strb, m1.w_last};
            b_sel_ready  = m1.b_ready;
        end
    end

    // Read FSM; a pending write start takes precedence when both are idle.
    always_comb begin
        r_next    = r_state;
        r_start_c = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (rd_req && (w_state == W_IDLE) && !wr_req) begin
                    r_next    = R_ADDR;
                    r_start_c = 1'b1;
                end
            end
            R_ADDR: begin
                if (ar_sel_valid && s.ar_ready) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (s.r_valid && r_sel_ready && s.r_last) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Write FSM; holds the grant from AW through the B response.
    always_comb begin
        w_next    = w_state;
        w_start_c = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (wr_req && (r_state == R_IDLE)) begin
                    w_next    = W_ADDR;
                    w_start_c = 1'b1;
                end
            end
            W_ADDR: begin
                if (aw_sel_valid && s.aw_ready) begin
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                if (w_sel_valid && s.w_ready && w_sel.last) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (s.b_valid && b_sel_ready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Read routing: handshakes only pass in the matching state, payloads always.
    always_comb begin
        s.ar_valid  = 1'b0;
        s.ar_addr   = ar_sel_addr;
        s.ar_len    = ar_sel_ctl.len;
        s.ar_size   = ar_sel_ctl.size;
        s.ar_burst  = ar_sel_ctl.burst;
        s.r_ready   = 1'b0;
        m0.ar_ready = 1'b0;
        m1.ar_ready = 1'b0;
        m0.r_valid  = 1'b0;
        m1.r_valid  = 1'b0;
        m0.r_last   = s.r_last;
        m1.r_last   = s.r_last;
        m0.r_rdata  = s.r_rdata;
        m1.r_rdata  = s.r_rdata;
        if (r_state == R_ADDR) begin
            s.ar_valid = ar_sel_valid;
            if (r_grant == M1) m1.ar_ready = s.ar_ready;
            else               m0.ar_ready = s.ar_ready;
        end
        if (r_state == R_DATA) begin
            s.r_ready = r_sel_ready;
            if (r_grant == M1) m1.r_valid = s.r_valid;
            else               m0.r_valid = s.r_valid;
        end
    end

    // Write routing, same scheme as reads.
    always_comb begin
        s.aw_valid  = 1'b0;
        s.aw_addr   = aw_sel_addr;
        s.aw_len    = aw_sel_ctl.len;
        s.aw_size   = aw_sel_ctl.size;
        s.aw_burst  = aw_sel_ctl.burst;
        s.w_valid   = 1'b0;
        s.w_data    = w_sel.data;
        s.w_strb    = w_sel.strb;
        s.w_last    = w_sel.last;
        s.b_ready   = 1'b0;
        m0.aw_ready = 1'b0;
        m1.aw_ready = 1'b0;
        m0.w_ready  = 1'b0;
        m1.w_ready  = 1'b0;
        m0.b_valid  = 1'b0;
        m1.b_valid  = 1'b0;
        if (w_state == W_ADDR) begin
            s.aw_valid = aw_sel_valid;
            if (w_grant == M1) m1.aw_ready = s.aw_ready;
            else               m0.aw_ready = s.aw_ready;
        end
        if (w_state == W_DATA) begin
            s.w_valid = w_sel_valid;
            if (w_grant == M1) m1.w_ready = s.w_ready;
            else               m0.w_ready = s.w_ready;
        end
        if (w_state == W_RESP) begin
            s.b_ready = b_sel_ready;
            if (w_grant == M1) m1.b_valid = s.b_valid;
            else               m0.b_valid = s.b_valid;
        end
    end

endmodule

// File: doc/axi_arbiter.md
AXI_ARBITER -- requirements
Module: axi_arbiter

Interface
REQ-001 SHALL have these ports: clock  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-002 SHALL have m0 (I-cache) and m1 (D-cache) upstream AXI ports, mN_ prefix, cache-side directions. Each port: ar_{valid,addr,len,size,burst} in 1/64/8/3/2; ar_ready out 1; r_{valid,last,rdata} out 1/1/64; r_ready in 1.
REQ-003 Each m0/m1 port SHALL also carry aw_{valid,addr,len,size,burst} in 1/64/8/3/2; aw_ready out 1; w_{valid,data,strb,last} in 1/64/8/1; w_ready out 1; b_valid out 1; b_ready in 1.
REQ-004 SHALL have one downstream port, s_ prefix, with the same signal set and directions reversed (master-side).
REQ-005 SHALL have the parameter ADDR_W, default 64, giving the address width of all ar_addr/aw_addr.

Function
REQ-006 Read and write channels SHALL be arbitrated by two independent FSMs.
REQ-007 Read FSM states SHALL be R_IDLE, R_ADDR and R_DATA.
REQ-008 Read FSM transitions: R_IDLE->R_ADDR when any mN_ar_valid and write FSM in W_IDLE; R_ADDR->R_DATA on s_ar handshake; R_DATA->R_IDLE on s_r handshake with s_r_last.
REQ-009 Read grant SHALL be registered on the R_IDLE->R_ADDR edge, giving +1 cycle AR latency.
REQ-010 Read grant SHALL be held unchanged until R_IDLE is re-entered.
REQ-011 Arbitration SHALL be round-robin per channel: on simultaneous requests, grant the master not granted last. After reset the last-grant pointer = m0, so m1 wins the first tie.
REQ-012 In R_ADDR, s_ar_* SHALL equal the granted master's ar_*, and its ar_ready SHALL equal s_ar_ready. Combinational pass-through, no buffering.
REQ-013 In R_DATA, the granted master's r_* SHALL equal s_r_*, and s_r_ready SHALL equal the granted master's r_ready.
REQ-014 The non-granted master SHALL see ar_ready=0 and r_valid=0 in every read state.
REQ-015 Write FSM states SHALL be W_IDLE, W_ADDR, W_DATA and W_RESP.
REQ-016 Write FSM transitions: W_IDLE->W_ADDR when any mN_aw_valid and read FSM in R_IDLE; W_ADDR->W_DATA on s_aw handshake; W_DATA->W_RESP on s_w handshake with w_last; W_RESP->W_IDLE on s_b handshake.
REQ-017 The write grant SHALL be held across AW, W and B. Routing rules SHALL match REQ-012/013/014 for aw/w/b.
REQ-018 Ordering rule: a new read grant SHALL NOT be issued while the write FSM is not W_IDLE, and a new write grant SHALL NOT be issued while the read FSM is not R_IDLE. This prevents a D-cache refill from overtaking its own write-back.
REQ-019 When both FSMs are idle and both channels request in the same cycle, the write SHALL win.
REQ-020 When no grant is active, all s_*_valid outputs and all s_*_ready outputs driven toward the slave SHALL be 0.
REQ-021 A mN_ar_valid or mN_aw_valid withdrawn before handshake is illegal upstream. The FSM SHALL remain in its ADDR state until handshake.
REQ-022 Burst length SHALL NOT be counted. Termination SHALL rely solely on r_last/w_last.

Reset
REQ-023 On reset: both FSMs go to IDLE, both last-grant pointers = m0, all valid and ready outputs = 0.
REQ-024 Reset mid-burst SHALL abandon the transaction without further handshakes.

Structure
REQ-025 FSM state encodings (2-bit read, 2-bit write) and master index constants SHALL live in the shared define package.
REQ-026 One sub-module SHALL be used: rr_arbiter2, a two-requester round-robin picker with registered last-grant pointer, instantiated once per channel.

Verification
REQ-027 Single read: m0 ar addr 0x80000000, len=1; slave returns two beats 0x11, 0x22. Required: m0 receives both beats in order, r_last on the second, m1 sees r_valid=0 throughout.
REQ-028 Simultaneous reads: m0 and m1 ar_valid assert in the same cycle after reset. Required: m1 granted first; m0 AR forwarded only after m1's r_last handshake.
REQ-029 Back-to-back: m1 completes a read, then m0 and m1 request again simultaneously. Required: m0 wins (round-robin).
REQ-030 Write-back then refill: m1 aw addr 0x80001000, len=1, two w beats, b_valid delayed 5 cycles; m1 ar to the same address requested during W_DATA. Required: s_ar_valid stays 0 until one cycle after the b handshake.
REQ-031 Stall: s_ar_ready held 0 for 10 cycles. Required: s_ar_addr stable throughout, grant unchanged.
REQ-032 Reset asserted during R_DATA. Required: the next cycle shows all valid outputs 0 and both FSMs in IDLE.
